activation_feeder: RTL

ACTIVATION_FEEDER -- requirements
Module: activation_feeder

---
 rtl/activation_feeder_if.sv | 14 +
 rtl/activation_feeder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/activation_feeder_if.sv
// Host word-access bus of the activation feeder: 32-bit slices addressed as {row, slice}.
// The master drives enables, address and write data; the slave returns registered read data.
interface activation_feeder_if #(
    parameter int HA_W = 15
);
    logic            s_en;
    logic [3:0]      s_we;
    logic [HA_W-1:0] s_addr;
    logic [31:0]     s_din;
    logic [31:0]     s_dout;

    modport master (output s_en, output s_we, output s_addr, output s_din, input s_dout);
    modport slave  (input s_en, input s_we, input s_addr, input s_din, output s_dout);
endinterface

// File: rtl/activation_feeder.sv
// Activation row buffer with a host word port and a streamer that reads rows in passes
// and feeds them into a systolic array, skewing lane i by i cycles.
module activation_feeder #(
    parameter int LANES      = 32,
    parameter int ACT_W      = 16,
    parameter int ROW_ADDR_W = 11,
    parameter int ROW_CNT_W  = 5,
    parameter int BATCH_W    = 6
) (
    input  logic                   clk,
    input  logic                   resetn,
    activation_feeder_if.slave     host,
    input  logic                   start,
    input  logic                   mode,
    input  logic [ROW_CNT_W-1:0]   last_row,
    input  logic [ROW_ADDR_W-1:0]  addr_start,
    input  logic [BATCH_W-1:0]     batch,
    input  logic                   hold,
    output logic [LANES*ACT_W-1:0] activation_in,
    output logic [LANES-1:0]       activation_in_valid,
    output logic                   busy,
    output logic                   done
);
    localparam int ROW_W  = LANES * ACT_W;
    localparam int SLICES = ROW_W / 32;
    localparam int SLC_W  = $clog2(SLICES);
    localparam int HA_W   = ROW_ADDR_W + SLC_W;
    localparam int DEPTH  = 1 << ROW_ADDR_W;
    localparam int DRN_W  = $clog2(LANES + 2);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;

    state_t                 state_q;
    logic                   mode_q;
    logic [ROW_CNT_W-1:0]   last_q;
    logic [BATCH_W-1:0]     batch_q;
    logic [ROW_ADDR_W-1:0]  base_q;
    logic [ROW_CNT_W-1:0]   row_q;
    logic [BATCH_W-1:0]     pass_q;
    logic [DRN_W-1:0]       drain_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   rv_q;

    logic [ROW_ADDR_W-1:0]  h_row;
    logic [SLC_W-1:0]       h_slc;
    logic                   h_wr;
    logic                   h_rd;
    logic [SLC_W-1:0]       hsel_q;
    logic                   hvld_q;
    logic [31:0]            hrd_word [SLICES];

    logic                   rd_en;
    logic [ROW_ADDR_W-1:0]  rd_addr;
    logic [ROW_W-1:0]       srd_row;

    assign h_row   = host.s_addr[HA_W-1:SLC_W];
    assign h_slc   = host.s_addr[SLC_W-1:0];
    assign h_wr    = host.s_en && (host.s_we != 4'h0);
    assign h_rd    = host.s_en && (host.s_we == 4'h0);

    assign rd_en   = (state_q == ST_RUN) && !hold;
    // Address arithmetic is ROW_ADDR_W wide, so row numbers wrap modulo DEPTH.
    assign rd_addr = base_q + ROW_ADDR_W'(row_q);

    // One 32-bit-wide RAM per slice: the host touches one slice, the streamer reads all.
    // Both reads are registered, so a same-cycle write is seen by neither (old data).
    genvar gi;
    generate
        for (gi = 0; gi < SLICES; gi++) begin : g_slice
            logic [31:0] mem [DEPTH];
            logic [31:0] hrd_q;
            logic [31:0] srd_q;

            always_ff @(posedge clk) begin
                if (h_wr && (h_slc == SLC_W'(gi))) begin
                    for (int b = 0; b < 4; b++) begin
                        if (host.s_we[b]) begin
                            mem[h_row][8*b +: 8] <= host.s_din[8*b +: 8];
                        end
                    end
                end
                if (h_rd && (h_slc == SLC_W'(gi))) begin
                    hrd_q <= mem[h_row];
                end
                if (rd_en) begin
                    srd_q <= mem[rd_addr];
                end
            end

            assign srd_row[32*gi +: 32] = srd_q;
            assign hrd_word[gi]         = hrd_q;
        end
    endgenerate

    // The RAM output registers carry no reset; hvld_q masks s_dout until a read lands.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hsel_q <= '0;
            hvld_q <= 1'b0;
        end else if (h_rd) begin
            hsel_q <= h_slc;
            hvld_q <= 1'b1;
        end
    end

    assign host.s_dout = hvld_q ? hrd_word[hsel_q] : 32'h0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            last_q  <= '0;
            batch_q <= '0;
            base_q  <= '0;
            row_q   <= '0;
            pass_q  <= '0;
            drain_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rv_q    <= 1'b0;
        end else if (hold) begin
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            rv_q   <= (state_q == ST_RUN);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mode_q  <= mode;
                        last_q  <= last_row;
                        batch_q <= batch;
                        base_q  <= addr_start;
                        row_q   <= '0;
                        pass_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (row_q == last_q) begin
                        row_q <= '0;
                        if (pass_q == batch_q) begin
                            // Last read issued: one cycle to the lane-0 register plus LANES of skew.
                            drain_q <= DRN_W'(LANES + 1);
                            state_q <= ST_DRAIN;
                        end else begin
                            pass_q <= pass_q + BATCH_W'(1);
                            if (mode_q) begin
                                base_q <= base_q + ROW_ADDR_W'(last_q) + ROW_ADDR_W'(1);
                            end
                        end
                    end else begin
                        row_q <= row_q + ROW_CNT_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_q == '0) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        drain_q <= drain_q - DRN_W'(1);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;

    // Lane gi delays the row word by gi+1 registers; invalid slots carry zero data.
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [ACT_W-1:0] pd_q [gi+1];
            logic [gi:0]      pv_q;

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    for (int k = 0; k <= gi; k++) begin
                        pd_q[k] <= '0;
                    end
                    pv_q <= '0;
                end else if (!hold) begin
                    pd_q[0] <= rv_q ? srd_row[gi*ACT_W +: ACT_W] : '0;
                    pv_q[0] <= rv_q;
                    for (int k = 1; k <= gi; k++) begin
                        pd_q[k] <= pd_q[k-1];
                        pv_q[k] <= pv_q[k-1];
                    end
                end
            end

            assign activation_in[gi*ACT_W +: ACT_W] = pd_q[gi];
            assign activation_in_valid[gi]          = pv_q[gi];
        end
    endgenerate
endmodule
